pwm_ramp_ctrl: RTL and testbench

AXI4-Lite master that configures and sequences the PWM slave for the Zybo motor path. On `start` it writes the period and enable registers, then ramps the duty register toward `target_duty` by `step` on each `tick`, issuing one AXI4-Lite write per duty update. It sits between the motor-control logic and the PWM peripheral's S00_AXI port. It replaces the BFM master used in block-level benches.

---
 rtl/pwm_ctrl_pkg.sv | 45 ++++
 rtl/axi_lite_wr_engine.sv | 95 +++++++++
 rtl/pwm_ramp_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: PWM slave register map,
// sequencer states and the duty-step arithmetic.
package pwm_ctrl_pkg;

    localparam logic [31:0] REG_PERIOD = 32'h0000_0000;
    localparam logic [31:0] REG_DUTY   = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL   = 32'h0000_0008;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_PERIOD,
        ST_CFG_EN,
        ST_RAMP,
        ST_WR_DUTY,
        ST_SHUT_DUTY,
        ST_SHUT_EN
    } state_e;

    // One ramp step toward tgt, clamped so it never passes the target.
    // The upward sum is 17 bits wide so a large step cannot wrap.
    function automatic logic [15:0] next_duty(input logic [15:0] cur,
                                              input logic [15:0] tgt,
                                              input logic [15:0] stp);
        logic [16:0] sum;
        logic [15:0] gap;
        next_duty = tgt;
        sum       = {1'b0, cur} + {1'b0, stp};
        gap       = '0;
        if (stp != '0) begin
            if (tgt > cur) begin
                if (sum < {1'b0, tgt}) begin
                    next_duty = sum[15:0];
                end
            end else if (tgt < cur) begin
                gap = cur - tgt;
                if (stp < gap) begin
                    next_duty = cur - stp;
                end
            end
        end
    endfunction

endpackage

// File: rtl/axi_lite_wr_engine.sv
// Single-outstanding AXI4-Lite write engine: one req pulse issues one write,
// done pulses for one cycle after the B handshake with the response in resp_o.
module axi_lite_wr_engine #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic                done_o,
    output logic [1:0]          resp_o,

    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [2:0]          awprot_o,
    output logic                awvalid_o,
    input  logic                awready_i,

    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,

    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o
);

    logic              aw_q, aw_d;
    logic              w_q, w_d;
    logic              act_q, act_d;
    logic              b_q, b_d;
    logic              done_q, done_d;
    logic [1:0]        resp_q, resp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        aw_d   = aw_q;
        w_d    = w_q;
        act_d  = act_q;
        addr_d = addr_q;
        data_d = data_q;
        if (req_i) begin
            aw_d   = 1'b1;
            w_d    = 1'b1;
            act_d  = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end else begin
            if (aw_q && awready_i) aw_d  = 1'b0;
            if (w_q && wready_i)   w_d   = 1'b0;
            if (b_q && bvalid_i)   act_d = 1'b0;
        end
        // bready waits until both address and data have been taken
        b_d    = act_d && !aw_d && !w_d;
        done_d = b_q && bvalid_i;
        resp_d = done_d ? bresp_i : resp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_q   <= 1'b0;
            w_q    <= 1'b0;
            act_q  <= 1'b0;
            b_q    <= 1'b0;
            done_q <= 1'b0;
            resp_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            aw_q   <= aw_d;
            w_q    <= w_d;
            act_q  <= act_d;
            b_q    <= b_d;
            done_q <= done_d;
            resp_q <= resp_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign awaddr_o  = addr_q;
    assign awprot_o  = '0;
    assign awvalid_o = aw_q;
    assign wdata_o   = data_q;
    assign wstrb_o   = '1;
    assign wvalid_o  = w_q;
    assign bready_o  = b_q;
    assign done_o    = done_q;
    assign resp_o    = resp_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM slave sequencer: configures PERIOD/CTRL on start, ramps DUTY one step
// per tick toward target_duty, and writes DUTY=0 then CTRL=0 on stop.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR       = 32'h43C0_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic                            start,
    input  logic                            stop,
    input  logic [31:0]                     period,
    input  logic [15:0]                     target_duty,
    input  logic [15:0]                     step,
    input  logic                            tick,

    output logic                            busy,
    output logic [15:0]                     cur_duty,
    output logic                            at_target,
    output logic                            error,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,

    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    state_e                        state_q, state_d;
    logic [15:0]                   cur_duty_q, cur_duty_d;
    logic [15:0]                   wr_duty_q, wr_duty_d;
    logic                          tick_pend_q, tick_pend_d;
    logic                          stop_pend_q, stop_pend_d;
    logic                          error_q, error_d;

    logic [15:0]                   duty_next;
    logic                          tick_any;
    logic                          stop_any;
    logic                          cur_eq_tgt;

    logic                          eng_req;
    logic                          eng_done;
    logic [1:0]                    eng_resp;
    logic [31:0]                   wr_ofs;
    logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] wr_data;

    assign duty_next  = next_duty(cur_duty_q, target_duty, step);
    assign tick_any   = tick_pend_q | tick;
    assign stop_any   = stop_pend_q | stop;
    assign cur_eq_tgt = (cur_duty_q == target_duty);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stop seen while a write is in flight is held in stop_pend_q and
    // acted on when that write's response arrives.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CFG_PERIOD;
            end
            ST_CFG_PERIOD: begin
                if (eng_done) state_d = stop_any ? ST_SHUT_DUTY : ST_CFG_EN;
            end
            ST_CFG_EN: begin
                if (eng_done) state_d = stop_any ? ST_SHUT_DUTY : ST_RAMP;
            end
            ST_RAMP: begin
                if (stop)                         state_d = ST_SHUT_DUTY;
                else if (tick_any && !cur_eq_tgt) state_d = ST_WR_DUTY;
            end
            ST_WR_DUTY: begin
                if (eng_done) state_d = stop_any ? ST_SHUT_DUTY : ST_RAMP;
            end
            ST_SHUT_DUTY: begin
                if (eng_done) state_d = ST_SHUT_EN;
            end
            ST_SHUT_EN: begin
                if (eng_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Each write is launched on the transition into its state, so the engine
    // raises its valids in the same cycle the new state becomes current.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        at_target = (state_q == ST_RAMP) && cur_eq_tgt;
        eng_req   = (state_d != state_q) && (state_d != ST_IDLE) && (state_d != ST_RAMP);
        wr_ofs    = REG_DUTY;
        wr_data   = '0;
        case (state_d)
            ST_CFG_PERIOD: begin
                wr_ofs  = REG_PERIOD;
                wr_data = C_M_AXI_DATA_WIDTH'(period);
            end
            ST_CFG_EN: begin
                wr_ofs  = REG_CTRL;
                wr_data = C_M_AXI_DATA_WIDTH'(1);
            end
            ST_WR_DUTY: begin
                wr_data = C_M_AXI_DATA_WIDTH'(duty_next);
            end
            ST_SHUT_EN: begin
                wr_ofs  = REG_CTRL;
            end
            default: ;
        endcase
        wr_addr = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(wr_ofs);
    end

    always_comb begin
        cur_duty_d  = cur_duty_q;
        wr_duty_d   = wr_duty_q;
        tick_pend_d = tick_pend_q | tick;
        stop_pend_d = stop_pend_q;
        error_d     = error_q;

        if (state_q == ST_IDLE) begin
            tick_pend_d = 1'b0;
        end else if (state_d == ST_WR_DUTY && state_q != ST_WR_DUTY) begin
            tick_pend_d = 1'b0;
            wr_duty_d   = duty_next;
        end else if (state_q == ST_RAMP && cur_eq_tgt) begin
            tick_pend_d = 1'b0;
        end

        if (state_q == ST_IDLE || state_d == ST_SHUT_DUTY) begin
            stop_pend_d = 1'b0;
        end else if (stop && (state_q inside {ST_CFG_PERIOD, ST_CFG_EN, ST_WR_DUTY})) begin
            stop_pend_d = 1'b1;
        end

        if (eng_done && state_q == ST_WR_DUTY)   cur_duty_d = wr_duty_q;
        if (eng_done && state_q == ST_SHUT_DUTY) cur_duty_d = '0;

        if (state_q == ST_IDLE && start) begin
            error_d = 1'b0;
        end else if (eng_done && eng_resp != RESP_OKAY) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cur_duty_q  <= '0;
            wr_duty_q   <= '0;
            tick_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            cur_duty_q  <= cur_duty_d;
            wr_duty_q   <= wr_duty_d;
            tick_pend_q <= tick_pend_d;
            stop_pend_q <= stop_pend_d;
            error_q     <= error_d;
        end
    end

    assign cur_duty = cur_duty_q;
    assign error    = error_q;

    axi_lite_wr_engine #(
        .ADDR_W (C_M_AXI_ADDR_WIDTH),
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_wr_engine (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .req_i     (eng_req),
        .addr_i    (wr_addr),
        .data_i    (wr_data),
        .done_o    (eng_done),
        .resp_o    (eng_resp),
        .awaddr_o  (m_axi_awaddr),
        .awprot_o  (m_axi_awprot),
        .awvalid_o (m_axi_awvalid),
        .awready_i (m_axi_awready),
        .wdata_o   (m_axi_wdata),
        .wstrb_o   (m_axi_wstrb),
        .wvalid_o  (m_axi_wvalid),
        .wready_i  (m_axi_wready),
        .bresp_i   (m_axi_bresp),
        .bvalid_i  (m_axi_bvalid),
        .bready_o  (m_axi_bready)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a configurable-latency AXI4-Lite slave
// that logs every completed write.
module tb_pwm_ramp_ctrl;

    localparam logic [31:0] BASE = 32'h43C0_0000;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period = '0;
    logic [15:0] target_duty = '0;
    logic [15:0] step = '0;
    logic        tick = 1'b0;
    logic        busy;
    logic [15:0] cur_duty;
    logic        at_target;
    logic        error;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    int passed = 0;
    int total  = 0;

    pwm_ramp_ctrl #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BASE_ADDR        (BASE)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .stop          (stop),
        .period        (period),
        .target_duty   (target_duty),
        .step          (step),
        .tick          (tick),
        .busy          (busy),
        .cur_duty      (cur_duty),
        .at_target     (at_target),
        .error         (error),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int err_idx = -1;
    int wr_count = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic        aw_now, w_now;
    logic [31:0] aw_addr_l = '0, w_data_l = '0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
    assign m_axi_bresp   = (wr_count == err_idx) ? 2'b10 : 2'b00;
    assign aw_now = aw_got || (m_axi_awvalid && m_axi_awready);
    assign w_now  = w_got || (m_axi_wvalid && m_axi_wready);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; m_axi_bvalid <= 1'b0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_got <= 1'b1; aw_addr_l <= m_axi_awaddr; aw_cnt <= 0;
            end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
            if (m_axi_wvalid && m_axi_wready) begin
                w_got <= 1'b1; w_data_l <= m_axi_wdata; w_cnt <= 0;
            end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                if (wr_count < 64) begin
                    log_addr[wr_count] <= aw_addr_l;
                    log_data[wr_count] <= w_data_l;
                end
                wr_count <= wr_count + 1;
            end else if (aw_now && w_now && !m_axi_bvalid) begin
                if (b_cnt >= b_dly) m_axi_bvalid <= 1'b1;
                else                b_cnt <= b_cnt + 1;
            end
        end
    end

    // valid/payload must hold from a cycle where valid is up and ready is not
    int viol = 0;
    logic        pv_aw = 1'b0, pv_w = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0;
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            pv_aw <= 1'b0; pv_w <= 1'b0;
        end else begin
            if ((pv_aw && !(m_axi_awvalid && m_axi_awaddr == p_awaddr)) ||
                (pv_w && !(m_axi_wvalid && m_axi_wdata == p_wdata)))
                viol <= viol + 1;
            pv_aw <= m_axi_awvalid && !m_axi_awready;
            pv_w  <= m_axi_wvalid && !m_axi_wready;
            p_awaddr <= m_axi_awaddr;
            p_wdata  <= m_axi_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(1); tick = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESETN = 1'b0;
        cyc(3);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, expected 0", busy); else passed++;
        total++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b000)
            $display("FAIL reset_axi: got %03b, expected 000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else passed++;
        total++; if (cur_duty !== 16'd0) $display("FAIL reset_cur_duty: got %0d, expected 0", cur_duty); else passed++;
        total++; if ({at_target, error} !== 2'b00) $display("FAIL reset_flags: got %02b, expected 00", {at_target, error}); else passed++;
        ARESETN = 1'b1;
        cyc(3);
        total++; if (busy !== 1'b0) $display("FAIL post_reset_idle: got %0b, expected 0", busy); else passed++;
    endtask

    task automatic test_ramp();
        int base;
        logic [31:0] ea [7] = '{BASE, BASE + 32'h8, BASE + 32'h4, BASE + 32'h4, BASE + 32'h4, BASE + 32'h4, BASE + 32'h4};
        logic [31:0] ed [7] = '{32'd1000, 32'd1, 32'd100, 32'd200, 32'd300, 32'd400, 32'd500};
        aw_dly = 0; w_dly = 0; b_dly = 0;
        period = 32'd1000; target_duty = 16'd500; step = 16'd100;
        base = wr_count;
        pulse_start();
        total++; if (!(m_axi_awvalid === 1'b1 && m_axi_wvalid === 1'b1 && m_axi_awaddr === BASE && m_axi_wdata === 32'd1000))
            $display("FAIL cfg_period_issue: got v=%0b addr=%0h data=%0d, expected v=1 addr=%0h data=1000", m_axi_awvalid, m_axi_awaddr, m_axi_wdata, BASE); else passed++;
        total++; if ({m_axi_awprot, m_axi_wstrb} !== 7'b000_1111)
            $display("FAIL prot_strb: got %0h/%0h, expected 0/f", m_axi_awprot, m_axi_wstrb); else passed++;
        cyc(3);
        total++; if (!(m_axi_awvalid === 1'b1 && m_axi_awaddr === BASE + 32'h8 && m_axi_wdata === 32'd1))
            $display("FAIL cfg_en_3cyc: got v=%0b addr=%0h data=%0d, expected v=1 addr=%0h data=1", m_axi_awvalid, m_axi_awaddr, m_axi_wdata, BASE + 32'h8); else passed++;
        cyc(6);
        total++; if ({busy, m_axi_awvalid} !== 2'b10) $display("FAIL ramp_quiet: got busy,awvalid=%02b, expected 10", {busy, m_axi_awvalid}); else passed++;
        pulse_tick();
        total++; if (!(m_axi_awvalid === 1'b1 && m_axi_awaddr === BASE + 32'h4 && m_axi_wdata === 32'd100))
            $display("FAIL tick_to_awvalid: got v=%0b addr=%0h data=%0d, expected v=1 duty 100", m_axi_awvalid, m_axi_awaddr, m_axi_wdata); else passed++;
        for (int t = 0; t < 6; t++) begin
            cyc(19);
            pulse_tick();
        end
        cyc(20);
        total++; if (wr_count - base !== 7) $display("FAIL ramp_write_count: got %0d, expected 7", wr_count - base); else passed++;
        for (int i = 0; i < 7; i++) begin
            total++; if (log_addr[base + i] !== ea[i] || log_data[base + i] !== ed[i])
                $display("FAIL ramp_write_%0d: got %0h=%0d, expected %0h=%0d", i, log_addr[base + i], log_data[base + i], ea[i], ed[i]); else passed++;
        end
        total++; if ({cur_duty, at_target} !== {16'd500, 1'b1})
            $display("FAIL ramp_final: got cur=%0d at=%0b, expected cur=500 at=1", cur_duty, at_target); else passed++;
    endtask

    task automatic test_overshoot();
        int base;
        target_duty = 16'd120; step = 16'd200;
        base = wr_count;
        cyc(1);
        total++; if (at_target !== 1'b0) $display("FAIL clamp_at_target_live: got %0b, expected 0", at_target); else passed++;
        pulse_tick(); cyc(20);
        pulse_tick(); cyc(20);
        total++; if (wr_count - base !== 2) $display("FAIL clamp_count: got %0d, expected 2", wr_count - base); else passed++;
        total++; if (log_data[base] !== 32'd300 || log_data[base + 1] !== 32'd120)
            $display("FAIL clamp_values: got %0d,%0d, expected 300,120", log_data[base], log_data[base + 1]); else passed++;
        total++; if ({cur_duty, at_target} !== {16'd120, 1'b1})
            $display("FAIL clamp_final: got cur=%0d at=%0b, expected cur=120 at=1", cur_duty, at_target); else passed++;
    endtask

    task automatic test_backpressure();
        int base, vbase;
        aw_dly = 3; w_dly = 1; b_dly = 5;
        target_duty = 16'd400; step = 16'd40;
        base = wr_count; vbase = viol;
        tick = 1'b1; cyc(1); tick = 1'b0;
        total++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) $display("FAIL bp_issue: got %02b, expected 11", {m_axi_awvalid, m_axi_wvalid}); else passed++;
        cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
        total++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100)
            $display("FAIL bp_w_drops_first: got %03b, expected 100", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else passed++;
        cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
        total++; if ({m_axi_awvalid, m_axi_bready} !== 2'b01)
            $display("FAIL bp_bready_after_both: got %02b, expected 01", {m_axi_awvalid, m_axi_bready}); else passed++;
        cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
        cyc(80);
        total++; if (wr_count - base !== 2) $display("FAIL bp_tick_collapse: got %0d writes, expected 2", wr_count - base); else passed++;
        total++; if (log_data[base] !== 32'd160 || log_data[base + 1] !== 32'd200)
            $display("FAIL bp_values: got %0d,%0d, expected 160,200", log_data[base], log_data[base + 1]); else passed++;
        total++; if ({cur_duty, at_target} !== {16'd200, 1'b0})
            $display("FAIL bp_final: got cur=%0d at=%0b, expected cur=200 at=0", cur_duty, at_target); else passed++;
        total++; if (viol - vbase !== 0) $display("FAIL bp_valid_stable: got %0d violations, expected 0", viol - vbase); else passed++;
    endtask

    task automatic test_stop_mid_write();
        int base;
        bit ok;
        aw_dly = 0; w_dly = 0; b_dly = 5;
        base = wr_count;
        pulse_tick();
        cyc(1);
        pulse_stop();
        total++; if ({busy, m_axi_bready} !== 2'b11) $display("FAIL stop_write_outstanding: got %02b, expected 11", {busy, m_axi_bready}); else passed++;
        wait_idle(200, ok);
        total++; if (ok !== 1'b1) $display("FAIL stop_reaches_idle: got busy=%0b, expected 0", busy); else passed++;
        total++; if (wr_count - base !== 3) $display("FAIL stop_count: got %0d, expected 3", wr_count - base); else passed++;
        total++; if (log_addr[base] !== BASE + 32'h4 || log_data[base] !== 32'd240)
            $display("FAIL stop_finish_duty: got %0h=%0d, expected %0h=240", log_addr[base], log_data[base], BASE + 32'h4); else passed++;
        total++; if (log_addr[base + 1] !== BASE + 32'h4 || log_data[base + 1] !== 32'd0)
            $display("FAIL stop_duty_zero: got %0h=%0d, expected %0h=0", log_addr[base + 1], log_data[base + 1], BASE + 32'h4); else passed++;
        total++; if (log_addr[base + 2] !== BASE + 32'h8 || log_data[base + 2] !== 32'd0)
            $display("FAIL stop_ctrl_zero: got %0h=%0d, expected %0h=0", log_addr[base + 2], log_data[base + 2], BASE + 32'h8); else passed++;
        total++; if ({cur_duty, busy} !== {16'd0, 1'b0})
            $display("FAIL stop_final: got cur=%0d busy=%0b, expected cur=0 busy=0", cur_duty, busy); else passed++;
    endtask

    task automatic test_error();
        int base;
        bit ok;
        aw_dly = 0; w_dly = 0; b_dly = 0;
        period = 32'd500; target_duty = 16'd300; step = 16'd100;
        base = wr_count;
        err_idx = base + 1;
        pulse_start();
        cyc(12);
        total++; if (error !== 1'b1) $display("FAIL err_set: got %0b, expected 1", error); else passed++;
        for (int t = 0; t < 3; t++) begin
            pulse_tick();
            cyc(19);
        end
        total++; if ({cur_duty, at_target, error} !== {16'd300, 1'b1, 1'b1})
            $display("FAIL err_ramp_continues: got cur=%0d at=%0b err=%0b, expected 300 1 1", cur_duty, at_target, error); else passed++;
        total++; if (log_data[base + 2] !== 32'd100) $display("FAIL err_first_duty: got %0d, expected 100", log_data[base + 2]); else passed++;
        err_idx = -1;
        pulse_stop();
        wait_idle(100, ok);
        total++; if (ok !== 1'b1 || error !== 1'b1)
            $display("FAIL err_sticky_idle: got idle=%0b err=%0b, expected 1 1", ok, error); else passed++;
        aw_dly = 3;
        pulse_start();
        total++; if (error !== 1'b0) $display("FAIL err_cleared_by_start: got %0b, expected 0", error); else passed++;
    endtask

    task automatic test_reset_mid();
        total++; if (m_axi_awvalid !== 1'b1) $display("FAIL rst_mid_precond: got awvalid=%0b, expected 1", m_axi_awvalid); else passed++;
        #1 ARESETN = 1'b0;
        #1;
        total++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b000)
            $display("FAIL rst_mid_axi_drop: got %03b, expected 000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_idle: got busy=%0b, expected 0", busy); else passed++;
        cyc(1);
        ARESETN = 1'b1;
        aw_dly = 0;
        cyc(3);
        total++; if ({busy, m_axi_awvalid} !== 2'b00) $display("FAIL rst_mid_stays_idle: got %02b, expected 00", {busy, m_axi_awvalid}); else passed++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_overshoot();
        test_backpressure();
        test_stop_mid_write();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
